// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and single-outstanding imem port.
// Optional bubble counter output when IF_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] if_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        slot_free;
    logic        accept;
    logic [31:0] tgt;

    assign slot_free = !valid_q || !id_stall;
    assign tgt       = {redirect_pc[31:2], 2'b00};
    assign imem_addr = pc_q;
    assign if_inst   = inst_q;
    assign if_pc     = ipc_q;
    assign if_valid  = valid_q;

    // Request is gated by slot_free so a full, stalled slot never gets a word.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        imem_req = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) pc_d = tgt;
                if (slot_free || redirect_valid) state_d = REQ;
            end
            REQ: begin
                imem_req = slot_free;
                if (redirect_valid) begin
                    pc_d    = tgt;
                    state_d = (slot_free && !imem_rvalid) ? DISCARD : REQ;
                end else if (slot_free && imem_rvalid) begin
                    accept  = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = id_stall ? IDLE : REQ;
                end
            end
            DISCARD: begin
                if (redirect_valid) pc_d = tgt;
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        if (redirect_valid) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end else if (accept) begin
            valid_d = 1'b1;
            inst_d  = imem_rdata;
            ipc_d   = pc_q;
        end else if (!id_stall) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            ipc_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] bub_q, bub_d;

    always_comb begin
        bub_d = bub_q;
        if (!id_stall && !valid_q && (bub_q != 32'hFFFF_FFFF))
            bub_d = bub_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) bub_q <= 32'd0;
        else      bub_q <= bub_d;
    end

    assign if_bubble_cnt = bub_q;
`endif

endmodule
